// File: rtl/mux_scan_pkg.sv
// Shared types, mode encodings and index arithmetic for the mux_scan_sel selector.
package mux_scan_pkg;

  typedef enum logic {MANUAL, SCAN} state_e;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Modular increment: idx+1, wrapping to 0 at n.
  function automatic int unsigned next_index(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mux_nx1.sv
// Combinational N-to-1 selector over a flattened bus; out-of-range select yields zero.
module mux_nx1 #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned NUM_IN = 6,
  parameter int unsigned SEL_W  = $clog2(NUM_IN)
) (
  input  logic [SEL_W-1:0]        sel_i,
  input  logic [NUM_IN*WIDTH-1:0] din_i,
  output logic [WIDTH-1:0]        dout_o
);

  always_comb begin
    dout_o = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (32'(sel_i) == k) dout_o = din_i[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/mux_scan_sel.sv
// Registered N-to-1 selector with manual select and dwell-timed auto-scan.
// Optional MUX_SCAN_SKIP_EN adds skip_mask to skip channels while scanning.
module mux_scan_sel
  import mux_scan_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned NUM_IN  = 6,
  parameter int unsigned SEL_W   = $clog2(NUM_IN),
  parameter int unsigned DWELL_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] din,
  input  logic [DWELL_W-1:0]      dwell,
`ifdef MUX_SCAN_SKIP_EN
  input  logic [NUM_IN-1:0]       skip_mask,
`endif
  output logic [WIDTH-1:0]        dout,
  output logic [SEL_W-1:0]        dout_sel,
  output logic                    dout_valid,
  output logic                    wrap
);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   dout_q, dout_d;
  logic               valid_q, valid_d;
  logic               wrap_q, wrap_d;

  logic               sel_legal;
  logic [SEL_W-1:0]   start_idx, entry_idx, adv_idx;
  logic               adv_wrap, all_masked;
  logic [WIDTH-1:0]   mux_dout;

  assign sel_legal = 32'(sel) < NUM_IN;
  assign start_idx = sel_legal ? sel : '0;

`ifdef MUX_SCAN_SKIP_EN
  // First unmasked channel at or after 'from' (strictly after when skip_self).
  function automatic logic [SEL_W-1:0] seek_free(input logic [SEL_W-1:0] from,
                                                 input logic skip_self);
    int unsigned cand;
    logic        found;
    seek_free = from;
    found     = 1'b0;
    cand      = skip_self ? next_index(32'(from), NUM_IN) : 32'(from);
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (!found && !skip_mask[cand]) begin
        seek_free = SEL_W'(cand);
        found     = 1'b1;
      end
      cand = next_index(cand, NUM_IN);
    end
  endfunction

  assign all_masked = &skip_mask;
  assign entry_idx  = seek_free(start_idx, 1'b0);
  assign adv_idx    = seek_free(idx_q, 1'b1);
  assign adv_wrap   = adv_idx <= idx_q;
`else
  assign all_masked = 1'b0;
  assign entry_idx  = start_idx;
  assign adv_idx    = SEL_W'(next_index(32'(idx_q), NUM_IN));
  assign adv_wrap   = idx_q == SEL_W'(NUM_IN - 1);
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    valid_d = 1'b1;
    wrap_d  = 1'b0;
    unique case (state_q)
      MANUAL: begin
        if (mode == MODE_SCAN) begin
          state_d = SCAN;
          cnt_d   = '0;
          idx_d   = entry_idx;
          valid_d = !all_masked;
        end else begin
          idx_d   = sel;
          valid_d = sel_legal;
        end
      end
      SCAN: begin
        if (mode == MODE_MANUAL) begin
          state_d = MANUAL;
          cnt_d   = '0;
          idx_d   = sel;
          valid_d = sel_legal;
        end else if (all_masked) begin
          valid_d = 1'b0;
        end else if (cnt_q == dwell) begin
          cnt_d  = '0;
          idx_d  = adv_idx;
          wrap_d = adv_wrap;
        end else begin
          // Free-running: a counter above a newly lowered dwell wraps through zero.
          cnt_d = cnt_q + DWELL_W'(1);
        end
      end
    endcase
    dout_d = valid_d ? mux_dout : '0;
  end

  mux_nx1 #(
    .WIDTH (WIDTH),
    .NUM_IN(NUM_IN),
    .SEL_W (SEL_W)
  ) u_mux (
    .sel_i (idx_d),
    .din_i (din),
    .dout_o(mux_dout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MANUAL;
      idx_q   <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end else begin
      wrap_q  <= 1'b0;
    end
  end

  assign dout       = dout_q;
  assign dout_sel   = idx_q;
  assign dout_valid = valid_q;
  assign wrap       = wrap_q;

endmodule
